// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the shared memory and the arbiter.
// Requests are level-held; each one completes with a single-cycle *_valid pulse and *_stall tracks req & ~valid.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data access,
// sequencing one transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
module unified_mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MEM_LATENCY   = 2,
   parameter int IF_STARVE_MAX = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   unified_mem_arbiter_if.slave    bus,
   output logic [1:0]              dbg_state
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STV_W = $clog2(IF_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STV_W-1:0] STV_MAX   = STV_W'(IF_STARVE_MAX);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_q;
   logic [STV_W-1:0]  starve_q;
   logic              grant_dm_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              grant;
   logic              pick_dm;

   always_comb begin
      state_d = state_q;
      grant   = (state_q == IDLE) && (bus.if_req || bus.dm_req);
      // DM is the older instruction, so it wins ties until IF has been passed over too often.
      pick_dm = bus.dm_req && !(bus.if_req && (starve_q == STV_MAX));
      case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   state_d = we_q ? RESP : WAIT;
         WAIT:    if (wait_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         starve_q   <= '0;
         grant_dm_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            grant_dm_q <= pick_dm;
            we_q       <= pick_dm && bus.dm_we;
            addr_q     <= pick_dm ? bus.dm_addr : bus.if_addr;
            wdata_q    <= pick_dm ? bus.dm_wdata : '0;
            if (pick_dm) begin
               if (bus.if_req && (starve_q != STV_MAX)) starve_q <= starve_q + STV_W'(1);
            end else begin
               starve_q <= '0;
            end
         end
         if (state_q == ISSUE) wait_q <= WAIT_LOAD;
         if (state_q == WAIT) begin
            if (wait_q == '0) begin
               if (grant_dm_q) dm_rdata_q <= bus.mem_rdata;
               else            if_rdata_q <= bus.mem_rdata;
            end else begin
               wait_q <= wait_q - CNT_W'(1);
            end
         end
      end
   end

   assign bus.mem_en    = (state_q == ISSUE);
   assign bus.mem_we    = (state_q == ISSUE) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_valid  = (state_q == RESP) && !grant_dm_q;
   assign bus.dm_valid  = (state_q == RESP) && grant_dm_q;
   assign bus.if_stall  = bus.if_req && !bus.if_valid;
   assign bus.dm_stall  = bus.dm_req && !bus.dm_valid;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a timestamp-based transaction model is checked
// every cycle, with literal expectations pinning the key latencies and grant order.
module tb_unified_mem_arbiter;
   localparam int ML   = 2;
   localparam int SMAX = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML), .IF_STARVE_MAX(SMAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- memory device ----------------
   logic [31:0] mem_arr [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   logic        s_en, s_we, s_rst, pend;
   logic [31:0] s_a, s_d, pend_data;
   int          pend_cnt;

   initial begin
      pend = 1'b0;
      pend_cnt = 0;
      pend_data = '0;
      bus.mem_rdata = 32'hBAD0_0000;
   end

   always @(posedge clk) begin
      s_en = bus.mem_en; s_we = bus.mem_we; s_a = bus.mem_addr; s_d = bus.mem_wdata; s_rst = rst_n;
      #1;
      bus.mem_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      if (!s_rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (pend_cnt == 0) begin bus.mem_rdata = pend_data; pend = 1'b0; end
            else pend_cnt--;
         end
         if (s_en && s_we) mem_arr[s_a] = s_d;
         else if (s_en) begin
            if (ML == 1) bus.mem_rdata = mem_read(s_a);
            else begin pend = 1'b1; pend_cnt = ML - 2; pend_data = mem_read(s_a); end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Transaction model: a grant at cycle g issues at g+1 and completes at g+ML+2 (load) or g+2 (store).
   logic        m_busy, m_dm, m_we;
   logic [31:0] m_addr, m_wdata, m_data, m_if_rd, m_dm_rd;
   int          m_grant, m_done, m_starve;
   logic        e_en, e_ifv, e_dmv;

   initial begin
      m_busy = 0; m_dm = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_data = 0;
      m_if_rd = 0; m_dm_rd = 0; m_grant = 0; m_done = 0; m_starve = 0;
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_busy = 0; m_starve = 0; m_if_rd = 0; m_dm_rd = 0;
         chk("rst_mem_en", 32'(bus.mem_en), 0);
         chk("rst_mem_we", 32'(bus.mem_we), 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
         chk("rst_if_valid", 32'(bus.if_valid), 0);
         chk("rst_dm_valid", 32'(bus.dm_valid), 0);
         chk("rst_if_rdata", bus.if_rdata, 0);
         chk("rst_dm_rdata", bus.dm_rdata, 0);
         chk("rst_if_stall", 32'(bus.if_stall), 32'(bus.if_req));
         chk("rst_dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req));
      end else begin
         e_en  = m_busy && (cyc == m_grant + 1);
         e_ifv = m_busy && (cyc == m_done) && !m_dm;
         e_dmv = m_busy && (cyc == m_done) && m_dm;
         if (m_busy && (cyc == m_done) && !m_we) begin
            if (m_dm) m_dm_rd = m_data;
            else      m_if_rd = m_data;
         end
         chk("mem_en", 32'(bus.mem_en), 32'(e_en));
         if (e_en) begin
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            chk("mem_addr", bus.mem_addr, m_addr);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
         end
         chk("if_valid", 32'(bus.if_valid), 32'(e_ifv));
         chk("dm_valid", 32'(bus.dm_valid), 32'(e_dmv));
         chk("if_rdata", bus.if_rdata, m_if_rd);
         chk("dm_rdata", bus.dm_rdata, m_dm_rd);
         chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !e_ifv));
         chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req && !e_dmv));
         if (m_busy && (cyc == m_done)) begin
            m_busy = 0;
         end else if (!m_busy && (bus.if_req || bus.dm_req)) begin
            m_dm    = bus.dm_req && !(bus.if_req && (m_starve == SMAX));
            m_we    = m_dm && bus.dm_we;
            m_addr  = m_dm ? bus.dm_addr : bus.if_addr;
            m_wdata = bus.dm_wdata;
            m_data  = mem_read(m_addr);
            m_busy  = 1;
            m_grant = cyc;
            m_done  = m_we ? cyc + 2 : cyc + ML + 2;
            if (!m_dm) m_starve = 0;
            else if (bus.if_req && m_starve < SMAX) m_starve++;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.if_req = 0; bus.if_addr = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
   endtask

   int grant_log[$];
   int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int vcount;
   int budget;

   initial begin
      idle_inputs();
      mem_arr[32'h40]  = 32'h0050_0093;
      mem_arr[32'h44]  = 32'h00A0_0113;
      mem_arr[32'h200] = 32'h1234_5678;

      // 1. reset held with random inputs, then idle
      for (int i = 0; i < 6; i++) begin
         step();
         bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
         bus.dm_req = 1'($urandom_range(0, 1)); bus.dm_we = 1'($urandom_range(0, 1));
         bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
      end
      at_neg();
      chk("lit_rst_state", 32'(dbg_state), 0);
      step();
      idle_inputs();
      rst_n = 1;
      step(4);
      at_neg();
      chk("lit_idle_no_en", 32'(bus.mem_en), 0);

      // 2. single fetch
      step();
      bus.if_req = 1; bus.if_addr = 32'h40;
      at_neg();
      chk("lit_fetch_stall_t", 32'(bus.if_stall), 1);
      step();
      at_neg();
      chk("lit_fetch_en", 32'(bus.mem_en), 1);
      chk("lit_fetch_addr", bus.mem_addr, 32'h40);
      step(3);
      at_neg();
      chk("lit_fetch_valid", 32'(bus.if_valid), 1);
      chk("lit_fetch_rdata", bus.if_rdata, 32'h0050_0093);
      step();
      bus.if_req = 0;
      step(2);

      // 3. single store
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
      step();
      at_neg();
      chk("lit_store_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd3);
      step();
      at_neg();
      chk("lit_store_valid", 32'(bus.dm_valid), 1);
      chk("lit_store_no_if", 32'(bus.if_valid), 0);
      step();
      idle_inputs();
      step(2);
      chk("lit_store_written", mem_read(32'h100), 32'hDEAD_BEEF);

      // 4. contested fetch and load
      bus.if_req = 1; bus.if_addr = 32'h44;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200;
      step(4);
      at_neg();
      chk("lit_contest_dm_valid", 32'(bus.dm_valid), 1);
      chk("lit_contest_dm_rdata", bus.dm_rdata, 32'h1234_5678);
      step();
      bus.dm_req = 0;
      at_neg();
      chk("lit_contest_if_stall", 32'(bus.if_stall), 1);
      step(4);
      at_neg();
      chk("lit_contest_if_valid", 32'(bus.if_valid), 1);
      chk("lit_contest_if_rdata", bus.if_rdata, 32'h00A0_0113);
      step();
      idle_inputs();
      step(2);

      // 5. sustained contention: grant order DM x4 then IF, repeating
      bus.if_req = 1; bus.if_addr = 32'h48;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300;
      budget = 0;
      while (grant_log.size() < 10 && budget < 200) begin
         at_neg();
         if (bus.mem_en) grant_log.push_back(int'(bus.mem_addr == 32'h48));
         budget++;
      end
      if (grant_log.size() < 10) begin
         checks++; errors++;
         $display("FAIL grant_order_timeout grants=%0d required=10", grant_log.size());
      end else begin
         for (int i = 0; i < 10; i++) chk($sformatf("lit_grant_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
      end
      step();
      idle_inputs();
      step(8);

      // 6. reset during the WAIT of a fetch
      bus.if_req = 1; bus.if_addr = 32'h40;
      step(2);
      rst_n = 0;
      bus.if_req = 0;
      at_neg();
      chk("lit_abort_state", 32'(dbg_state), 0);
      chk("lit_abort_rdata", bus.if_rdata, 0);
      step(2);
      rst_n = 1;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         at_neg();
         if (bus.if_valid) vcount++;
      end
      chk("lit_abort_no_valid", 32'(vcount), 0);
      step();
      bus.if_req = 1; bus.if_addr = 32'h44;
      step(4);
      at_neg();
      chk("lit_refetch_valid", 32'(bus.if_valid), 1);
      chk("lit_refetch_rdata", bus.if_rdata, 32'h00A0_0113);
      step();
      idle_inputs();
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
